// File: rtl/rb_port_arbiter_if.sv
// Requester-side and register-bank-side signals of the register-bank port arbiter.
// master = arbiter view, slave = requesters plus bank view.
interface rb_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 4,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_i;
  logic [NREQ-1:0]    rw_i;
  logic [NREQ*AW-1:0] addr_i;
  logic [NREQ*DW-1:0] wdata_i;
  logic [NREQ-1:0]    gnt_o;
  logic [NREQ-1:0]    done_o;
  logic               err_o;
  logic [DW-1:0]      rdata_o;

  logic               rb_trig_o;
  logic               rb_rw_o;
  logic [AW-1:0]      rb_addr_o;
  logic [DW-1:0]      rb_wdata_o;
  logic               rb_ack_i;
  logic [DW-1:0]      rb_rdata_i;
  logic               sem_o;

  modport master (
    input  req_i, rw_i, addr_i, wdata_i, rb_ack_i, rb_rdata_i,
    output gnt_o, done_o, err_o, rdata_o,
    output rb_trig_o, rb_rw_o, rb_addr_o, rb_wdata_o, sem_o
  );

  modport slave (
    output req_i, rw_i, addr_i, wdata_i, rb_ack_i, rb_rdata_i,
    input  gnt_o, done_o, err_o, rdata_o,
    input  rb_trig_o, rb_rw_o, rb_addr_o, rb_wdata_o, sem_o
  );
endinterface

// File: rtl/rb_port_arbiter.sv
// Round-robin arbiter sharing one register-bank port via a toggle trigger/ack handshake.
// Optional macro RB_WRITE_PRIORITY_EN: pending writes win arbitration over reads.
module rb_port_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rb_port_arbiter_if.master    bus
);

  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [RRW-1:0]  rr_q, rr_d;
  logic [RRW-1:0]  win_q, win_d;
  logic            ack_prev_q, ack_prev_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            trig_q, trig_d;
  logic            rw_q, rw_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            sem_q, sem_d;

  logic [AW-1:0]   addr_sl  [NREQ];
  logic [DW-1:0]   wdata_sl [NREQ];
  logic [NREQ-1:0] cand_mask;
  logic            win_found;
  logic [RRW-1:0]  win_idx;
  logic [RRW-1:0]  next_rr;
  logic            ack_edge;
  logic            finish;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign addr_sl[gi]  = bus.addr_i[gi*AW +: AW];
      assign wdata_sl[gi] = bus.wdata_i[gi*DW +: DW];
    end
  endgenerate

`ifdef RB_WRITE_PRIORITY_EN
  // Writers only when any writer is pending; rr pointer is shared with reads.
  assign cand_mask = (|(bus.req_i & bus.rw_i)) ? (bus.req_i & bus.rw_i) : bus.req_i;
`else
  assign cand_mask = bus.req_i;
`endif

  // First candidate searching upward from rr_q, wrapping at NREQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      logic [RRW:0] cand;
      cand = {1'b0, rr_q} + (RRW+1)'(i);
      if (cand >= (RRW+1)'(NREQ)) cand = cand - (RRW+1)'(NREQ);
      if (!win_found && cand_mask[cand[RRW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[RRW-1:0];
      end
    end
  end

  always_comb begin
    logic [RRW:0] inc;
    inc     = {1'b0, win_q} + (RRW+1)'(1);
    next_rr = (inc >= (RRW+1)'(NREQ)) ? '0 : inc[RRW-1:0];
  end

  assign ack_edge = (bus.rb_ack_i != ack_prev_q);

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    win_d      = win_q;
    ack_prev_d = ack_prev_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    trig_d     = trig_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sem_d      = sem_q;
    finish     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          win_d          = win_idx;
          rw_d           = bus.rw_i[win_idx];
          addr_d         = addr_sl[win_idx];
          wdata_d        = wdata_sl[win_idx];
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        trig_d  = ~trig_q;
        sem_d   = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // An ack arriving on the timeout edge still completes normally.
        if (ack_edge) begin
          ack_prev_d = bus.rb_ack_i;
          if (!rw_q) rdata_d = bus.rb_rdata_i;
          finish = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d  = 1'b1;
          finish = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (finish) begin
          done_d        = '0;
          done_d[win_q] = 1'b1;
          gnt_d         = '0;
          sem_d         = 1'b0;
          rr_d          = next_rr;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      win_q      <= '0;
      ack_prev_q <= 1'b0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      trig_q     <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sem_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      win_q      <= win_d;
      ack_prev_q <= ack_prev_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      trig_q     <= trig_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sem_q      <= sem_d;
    end
  end

  assign bus.gnt_o      = gnt_q;
  assign bus.done_o     = done_q;
  assign bus.err_o      = err_q;
  assign bus.rdata_o    = rdata_q;
  assign bus.rb_trig_o  = trig_q;
  assign bus.rb_rw_o    = rw_q;
  assign bus.rb_addr_o  = addr_q;
  assign bus.rb_wdata_o = wdata_q;
  assign bus.sem_o      = sem_q;

endmodule

// File: tb/tb_rb_port_arbiter.sv
// Directed, table-driven bench for rb_port_arbiter (NREQ=4, AW=4, DW=32, TIMEOUT=16).
module tb_rb_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int TO   = 16;
  localparam int NV   = 7;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  rb_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  rb_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   req;
    logic [3:0]   rw;
    logic [15:0]  addr;
    logic [127:0] wdata;
    int           delay;
    logic [31:0]  bank_rdata;
    logic [3:0]   exp_gnt;
    logic         exp_rw;
    logic [3:0]   exp_addr;
    logic [31:0]  exp_wdata;
    int           exp_lat;
    logic         exp_err;
    logic [31:0]  exp_rdata;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    logic got;
    logic trig_exp;

    n_pass  = 0;
    n_total = 0;
    vecs[0] = '{req:4'b0001, rw:4'b0000, addr:16'h0003, wdata:'0, delay:2,
                bank_rdata:32'hDEADBEEF, exp_gnt:4'b0001, exp_rw:1'b0, exp_addr:4'h3,
                exp_wdata:32'h0, exp_lat:3, exp_err:1'b0, exp_rdata:32'hDEADBEEF};
    vecs[1] = '{req:4'b0010, rw:4'b0010, addr:16'h00F0, wdata:{32'h0, 32'h0, 32'h12345678, 32'h0},
                delay:0, bank_rdata:32'hBAD0BAD0, exp_gnt:4'b0010, exp_rw:1'b1, exp_addr:4'hF,
                exp_wdata:32'h12345678, exp_lat:1, exp_err:1'b0, exp_rdata:32'hDEADBEEF};
    vecs[2] = '{req:4'b1001, rw:4'b0000, addr:16'h7000, wdata:'0, delay:1,
                bank_rdata:32'hCAFEF00D, exp_gnt:4'b1000, exp_rw:1'b0, exp_addr:4'h7,
                exp_wdata:32'h0, exp_lat:2, exp_err:1'b0, exp_rdata:32'hCAFEF00D};
    vecs[3] = '{req:4'b0100, rw:4'b0000, addr:16'h0500, wdata:'0, delay:1000,
                bank_rdata:32'h11111111, exp_gnt:4'b0100, exp_rw:1'b0, exp_addr:4'h5,
                exp_wdata:32'h0, exp_lat:TO, exp_err:1'b1, exp_rdata:32'hCAFEF00D};
    vecs[4] = '{req:4'b0101, rw:4'b0000, addr:16'h0009, wdata:'0, delay:0,
                bank_rdata:32'h00000001, exp_gnt:4'b0001, exp_rw:1'b0, exp_addr:4'h9,
                exp_wdata:32'h0, exp_lat:1, exp_err:1'b0, exp_rdata:32'h00000001};
    vecs[5] = '{req:4'b1000, rw:4'b0000, addr:16'hC000, wdata:'0, delay:0,
                bank_rdata:32'h24681357, exp_gnt:4'b1000, exp_rw:1'b0, exp_addr:4'hC,
                exp_wdata:32'h0, exp_lat:1, exp_err:1'b0, exp_rdata:32'h24681357};
`ifdef RB_WRITE_PRIORITY_EN
    vecs[6] = '{req:4'b0101, rw:4'b0100, addr:16'h0A02, wdata:{32'h0, 32'h55AA55AA, 32'h0, 32'h0},
                delay:0, bank_rdata:32'h13579BDF, exp_gnt:4'b0100, exp_rw:1'b1, exp_addr:4'hA,
                exp_wdata:32'h55AA55AA, exp_lat:1, exp_err:1'b0, exp_rdata:32'h24681357};
`else
    vecs[6] = '{req:4'b0101, rw:4'b0100, addr:16'h0A02, wdata:{32'h0, 32'h55AA55AA, 32'h0, 32'h0},
                delay:0, bank_rdata:32'h13579BDF, exp_gnt:4'b0001, exp_rw:1'b0, exp_addr:4'h2,
                exp_wdata:32'h0, exp_lat:1, exp_err:1'b0, exp_rdata:32'h13579BDF};
`endif

    rst_n          = 1'b0;
    bus.req_i      = '0;
    bus.rw_i       = '0;
    bus.addr_i     = '0;
    bus.wdata_i    = '0;
    bus.rb_ack_i   = 1'b0;
    bus.rb_rdata_i = '0;
    step();
    step();
    chk("rst_gnt",   bus.gnt_o,      '0);
    chk("rst_done",  bus.done_o,     '0);
    chk("rst_err",   bus.err_o,      '0);
    chk("rst_rdata", bus.rdata_o,    '0);
    chk("rst_trig",  bus.rb_trig_o,  '0);
    chk("rst_sem",   bus.sem_o,      '0);
    chk("rst_addr",  bus.rb_addr_o,  '0);
    chk("rst_wdata", bus.rb_wdata_o, '0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      bus.req_i      = v.req;
      bus.rw_i       = v.rw;
      bus.addr_i     = v.addr;
      bus.wdata_i    = v.wdata;
      bus.rb_rdata_i = v.bank_rdata;
      trig_exp       = ~bus.rb_trig_o;
      step();
      chk($sformatf("v%0d_gnt", i), bus.gnt_o, v.exp_gnt);
      chk($sformatf("v%0d_sem_grant", i), bus.sem_o, 1'b0);
      step();
      chk($sformatf("v%0d_trig", i), bus.rb_trig_o, trig_exp);
      chk($sformatf("v%0d_sem", i), bus.sem_o, 1'b1);
      chk($sformatf("v%0d_rw", i), bus.rb_rw_o, v.exp_rw);
      chk($sformatf("v%0d_addr", i), bus.rb_addr_o, v.exp_addr);
      chk($sformatf("v%0d_wdata", i), bus.rb_wdata_o, v.exp_wdata);
      n   = 0;
      got = 1'b0;
      while (!got && n < 40) begin
        if (n == v.delay) bus.rb_ack_i = ~bus.rb_ack_i;
        step();
        n++;
        if (|bus.done_o) got = 1'b1;
      end
      chk($sformatf("v%0d_latency", i), n, v.exp_lat);
      chk($sformatf("v%0d_done", i), bus.done_o, v.exp_gnt);
      chk($sformatf("v%0d_err", i), bus.err_o, v.exp_err);
      chk($sformatf("v%0d_rdata", i), bus.rdata_o, v.exp_rdata);
      chk($sformatf("v%0d_sem_done", i), bus.sem_o, 1'b0);
      chk($sformatf("v%0d_gnt_done", i), bus.gnt_o, '0);
      bus.req_i = '0;
      step();
      chk($sformatf("v%0d_done_pulse", i), bus.done_o, '0);
      chk($sformatf("v%0d_err_pulse", i), bus.err_o, 1'b0);
      $display("vector %0d: req=%b gnt=%b latency=%0d rdata=%h", i, v.req, v.exp_gnt, n, bus.rdata_o);
    end

    // Reset asserted while WAITing: outputs clear without a clock edge, no done.
    rst_n = 1'b0;
    bus.rb_ack_i = 1'b0;
    #2;
    rst_n = 1'b1;
    bus.req_i      = 4'b0010;
    bus.rw_i       = 4'b0000;
    bus.addr_i     = 16'h0040;
    bus.rb_rdata_i = 32'h77777777;
    step();
    chk("rstw_gnt", bus.gnt_o, 4'b0010);
    step();
    step();
    step();
    chk("rstw_sem_wait", bus.sem_o, 1'b1);
    #2;
    rst_n = 1'b0;
    bus.rb_ack_i = 1'b0;
    #1;
    chk("rstw_async_gnt",  bus.gnt_o,     '0);
    chk("rstw_async_sem",  bus.sem_o,     '0);
    chk("rstw_async_trig", bus.rb_trig_o, '0);
    chk("rstw_async_addr", bus.rb_addr_o, '0);
    step();
    chk("rstw_no_done", bus.done_o, '0);
    rst_n = 1'b1;
    step();
    chk("rstw_regnt", bus.gnt_o, 4'b0010);
    step();
    chk("rstw_resem", bus.sem_o, 1'b1);
    bus.rb_ack_i = ~bus.rb_ack_i;
    step();
    chk("rstw_done",  bus.done_o,  4'b0010);
    chk("rstw_rdata", bus.rdata_o, 32'h77777777);
    $display("reset-in-wait: regrant done=%b rdata=%h", bus.done_o, bus.rdata_o);
    bus.req_i = '0;
    step();

    // Fairness from rr=0 with all four requesting and an immediate bank.
    rst_n = 1'b0;
    bus.rb_ack_i = 1'b0;
    #2;
    rst_n = 1'b1;
    bus.req_i = 4'b1111;
    bus.rw_i  = 4'b0000;
    bus.addr_i = 16'h3210;
    for (int t = 0; t < 5; t++) begin
      logic [3:0] eg;
      eg = 4'b0001 << (t % NREQ);
      step();
      chk($sformatf("fair%0d_gnt", t), bus.gnt_o, eg);
      step();
      chk($sformatf("fair%0d_sem", t), bus.sem_o, 1'b1);
      bus.rb_ack_i = ~bus.rb_ack_i;
      step();
      chk($sformatf("fair%0d_done", t), bus.done_o, eg);
      $display("fairness %0d: gnt=%b done=%b", t, eg, bus.done_o);
    end
    bus.req_i = '0;
    step();
    chk("fair_idle_gnt", bus.gnt_o, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
